// File: rtl/priority_encoder_rr.sv
// Registered priority encoder with valid/ready output: fixed highest-index
// priority (MODE=0) or round-robin searching downward from a pointer (MODE=1).
module priority_encoder_rr #(
  parameter  int N    = 8,
  parameter  int MODE = 0,
  localparam int W    = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] in,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out,
  output logic [N-1:0] out_onehot
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   ptr, ptr_nxt, srch, win;
  logic [N-1:0]   onehot_nxt;
  logic           hs, load;

  assign hs      = (state == HOLD) && out_ready;
  assign load    = ((state == IDLE) || hs) && en && (|in);
  assign ptr_nxt = (out == '0) ? W'(N - 1) : out - W'(1);

  // Fixed priority is the downward search started at N-1; a grant in the
  // handshake cycle must already see the pointer that handshake produces.
  assign srch = (MODE == 1) ? (hs ? ptr_nxt : ptr) : W'(N - 1);

  always_comb begin
    win = '0;
    for (int k = N - 1; k >= 0; k--) begin
      int j;
      j = int'(srch) - k;
      if (j < 0) j = j + N;
      if (in[j]) win = W'(j);
    end
    onehot_nxt      = '0;
    onehot_nxt[win] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = HOLD;
      HOLD:    if (hs) state_nxt = load ? HOLD : IDLE;
               else if (!en) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state == HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out        <= '0;
      out_onehot <= '0;
      ptr        <= W'(N - 1);
    end else begin
      if (load) begin
        out        <= win;
        out_onehot <= onehot_nxt;
      end else if (state_nxt == IDLE) begin
        out        <= '0;
        out_onehot <= '0;
      end
      if (MODE == 1 && hs) ptr <= ptr_nxt;
    end
  end

endmodule

// File: tb/tb_priority_encoder_rr.sv
// Checks both arbitration modes side by side against fixed vectors and a
// reference model driven by random traffic.
module tb_priority_encoder_rr;
  localparam int N = 8;

  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, rdy = 1'b0;
  logic [N-1:0] in = '0;
  logic v0, v1;
  logic [2:0] o0, o1;
  logic [N-1:0] h0, h1;

  int checks = 0, errors = 0;
  int mv[2], mo[2], mp[2];

  always #5 clk = ~clk;

  priority_encoder_rr #(.N(N), .MODE(0)) d0 (.clk(clk), .rst_n(rst_n), .en(en), .in(in),
    .out_ready(rdy), .out_valid(v0), .out(o0), .out_onehot(h0));
  priority_encoder_rr #(.N(N), .MODE(1)) d1 (.clk(clk), .rst_n(rst_n), .en(en), .in(in),
    .out_ready(rdy), .out_valid(v1), .out(o1), .out_onehot(h1));

  typedef struct {
    logic en; logic [7:0] in; logic rdy;
    int v0; int o0; int v1; int o1;
  } vec_t;
  vec_t tbl[16];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int rr_win(input int p, input logic [7:0] v);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (p - k + N) % N;
      if (v[idx]) return idx;
    end
    return 0;
  endfunction

  function automatic int top_bit(input logic [7:0] v);
    return $clog2(int'(v) + 1) - 1;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin mv[m] = 0; mo[m] = 0; mp[m] = N - 1; end
  endtask

  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      bit hs, ld;
      hs = (mv[m] != 0) && rdy;
      if (hs && m == 1) mp[m] = (mo[m] == 0) ? N - 1 : mo[m] - 1;
      ld = ((mv[m] == 0) || hs) && en && (in != 0);
      if (ld) begin
        mo[m] = (m == 1) ? rr_win(mp[m], in) : top_bit(in);
        mv[m] = 1;
      end else if ((mv[m] == 0) || hs || !en) begin
        mv[m] = 0; mo[m] = 0;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk); #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, " m0 valid"}, int'(v0), mv[0]);
    chk({tag, " m0 out"}, int'(o0), mo[0]);
    chk({tag, " m0 onehot"}, int'(h0), mv[0] ? (1 << mo[0]) : 0);
    chk({tag, " m1 valid"}, int'(v1), mv[1]);
    chk({tag, " m1 out"}, int'(o1), mo[1]);
    chk({tag, " m1 onehot"}, int'(h1), mv[1] ? (1 << mo[1]) : 0);
  endtask

  initial begin
    //           en  in      rdy v0 o0 v1 o1
    tbl[0]  = '{1'b1, 8'h2C, 1'b1, 1, 5, 1, 5};
    tbl[1]  = '{1'b0, 8'h00, 1'b1, 0, 0, 0, 0};
    tbl[2]  = '{1'b1, 8'h01, 1'b0, 1, 0, 1, 0};
    tbl[3]  = '{1'b1, 8'h80, 1'b0, 1, 0, 1, 0};
    tbl[4]  = '{1'b1, 8'h80, 1'b0, 1, 0, 1, 0};
    tbl[5]  = '{1'b1, 8'h80, 1'b1, 1, 7, 1, 7};
    tbl[6]  = '{1'b1, 8'h80, 1'b1, 1, 7, 1, 7};
    tbl[7]  = '{1'b1, 8'h83, 1'b1, 1, 7, 1, 1};
    tbl[8]  = '{1'b1, 8'h83, 1'b1, 1, 7, 1, 0};
    tbl[9]  = '{1'b1, 8'h83, 1'b1, 1, 7, 1, 7};
    tbl[10] = '{1'b1, 8'h83, 1'b1, 1, 7, 1, 1};
    tbl[11] = '{1'b0, 8'h83, 1'b0, 0, 0, 0, 0};
    tbl[12] = '{1'b1, 8'h08, 1'b0, 1, 3, 1, 3};
    tbl[13] = '{1'b0, 8'h08, 1'b0, 0, 0, 0, 0};
    tbl[14] = '{1'b1, 8'h08, 1'b0, 1, 3, 1, 3};
    tbl[15] = '{1'b1, 8'h00, 1'b1, 0, 0, 0, 0};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset m0 valid", int'(v0), 0);
    chk("reset m0 out", int'(o0), 0);
    chk("reset m1 onehot", int'(h1), 0);
    #3 rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      en = tbl[i].en; in = tbl[i].in; rdy = tbl[i].rdy;
      tick();
      chk($sformatf("vec%0d m0 valid", i), int'(v0), tbl[i].v0);
      chk($sformatf("vec%0d m0 out", i), int'(o0), tbl[i].o0);
      chk($sformatf("vec%0d m0 onehot", i), int'(h0), tbl[i].v0 ? (1 << tbl[i].o0) : 0);
      chk($sformatf("vec%0d m1 valid", i), int'(v1), tbl[i].v1);
      chk($sformatf("vec%0d m1 out", i), int'(o1), tbl[i].o1);
    end

    // Asynchronous reset mid-HOLD, then first round-robin grant matches fixed priority.
    en = 1'b1; in = 8'h10; rdy = 1'b0;
    tick();
    chk("pre-reset m1 valid", int'(v1), 1);
    #3 rst_n = 1'b0;
    #1;
    chk("async reset m0 valid", int'(v0), 0);
    chk("async reset m1 valid", int'(v1), 0);
    chk("async reset m1 onehot", int'(h1), 0);
    model_reset();
    #1 rst_n = 1'b1;
    en = 1'b1; in = 8'h42; rdy = 1'b1;
    tick();
    chk("post-reset m0 out", int'(o0), 6);
    chk("post-reset m1 out", int'(o1), 6);
    chk_model("post-reset");

    for (int c = 0; c < 400; c++) begin
      en  = ($urandom_range(0, 7) != 0);
      in  = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      rdy = ($urandom_range(0, 2) != 0);
      tick();
      chk_model($sformatf("rand%0d", c));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/priority_encoder_rr.md
PRIORITY_ENCODER_RR -- requirements
Module: priority_encoder_rr

Interface
REQ-001 Parameter N, default 8, number of request lines; legal range 2..64.
REQ-002 Parameter MODE, default 0, arbitration mode; 0 = fixed priority with the highest index winning, 1 = round-robin.
REQ-003 Derived parameter W = clog2(N), width of the index output; not user-overridable.
REQ-004 clk  input  1  single clock, rising-edge active.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 en  input  1  encoder enable.
REQ-007 in  input  N  request vector; bit i set means requester i is active.
REQ-008 out_ready  input  1  downstream accepts out this cycle.
REQ-009 out_valid  output  1  out / out_onehot hold a valid winner.
REQ-010 out  output  W  registered index of the winning request.
REQ-011 out_onehot  output  N  registered one-hot form of out; all-zero when out_valid=0.

Function
REQ-012 The block SHALL be a two-state FSM: IDLE (out_valid=0) and HOLD (out_valid=1).
REQ-013 In IDLE with en=1 and in!=0, the block SHALL compute the winner from in, register it, and enter HOLD; out_valid rises one clock after in is sampled (latency 1).
REQ-014 In IDLE with en=0 or in==0, the block SHALL stay in IDLE with out=0 and out_onehot=0.
REQ-015 In HOLD, out and out_onehot SHALL stay stable until a handshake (out_valid=1 and out_ready=1); later changes on in SHALL NOT alter them.
REQ-016 On a handshake with en=1 and in!=0 in the same cycle, the block SHALL load the next winner and stay in HOLD, giving back-to-back grants with no bubble.
REQ-017 On a handshake with en=0 or in==0, the block SHALL return to IDLE, clearing out, out_onehot and out_valid.
REQ-018 In HOLD with en=0 and no handshake, the block SHALL abort to IDLE on the next edge with out_valid=0; the RR pointer is not updated.
REQ-019 MODE=0: winner SHALL be the highest set index of in; pointer unused.
REQ-020 MODE=1: a W-bit pointer ptr SHALL select the winner as the first set bit found searching downward from ptr, wrapping from index 0 to N-1.
REQ-021 MODE=1: on each handshake, ptr SHALL become (out-1) mod N, so index 0 wraps to N-1; ptr SHALL be unchanged otherwise.
REQ-022 For ptr arithmetic with N not a power of two, the wrap target SHALL be N-1, never 2^W-1; out SHALL never exceed N-1.
REQ-023 out_onehot SHALL equal 1<<out whenever out_valid=1.
REQ-024 X/Z on in is not a supported input; the bench SHALL drive only 0 and 1.

Reset
REQ-025 While rst_n=0, the block SHALL hold state=IDLE, out_valid=0, out=0, out_onehot=0 and ptr=N-1, taking effect asynchronously.
REQ-026 Reset asserted in HOLD SHALL drop out_valid immediately, without waiting for a clock edge; no handshake is counted.
REQ-027 Deassertion of rst_n SHALL be synchronous to clk; the first sample of in occurs on the first rising edge with rst_n=1.
REQ-028 With ptr=N-1 after reset, MODE=1 SHALL produce the same first winner as MODE=0.

Verification (N=8)
REQ-029 MODE=0, en=1, in=8'b0010_1100, out_ready=1 -> next cycle out_valid=1, out=5, out_onehot=8'b0010_0000.
REQ-030 MODE=0, in=8'b0000_0001, out_ready=0 for 3 cycles, then in changed to 8'b1000_0000 -> out stays 0 until out_ready=1; the cycle after the handshake gives out=7.
REQ-031 MODE=1, in held at 8'b1000_0011, out_ready=1 continuously -> out sequence 7,1,0,7,1 with out_valid=1 every cycle and no bubble.
REQ-032 MODE=1, in=8'b0000_0001 accepted, then in=8'b1000_0001 -> ptr=7 after the wrap, next out=7.
REQ-033 HOLD with out=3, then en=0 with out_ready=0 -> out_valid=0 next cycle; ptr unchanged, so re-enabling with the same in gives out=3 again.
REQ-034 rst_n pulsed low mid-HOLD between clock edges -> out_valid=0 immediately; after release, MODE=1 with in=8'b0100_0010 gives out=6.
